hazard_forward_ctrl: RTL and testbench
======================================

// Module: hazard_forward_ctrl
// PURPOSE
// - Hazard/forwarding controller for the 5-stage pipeline (F/D/E/M/W).
// - Tracks rd/regwrite/load of in-flight instructions in an internal shadow pipeline.
// - Drives the two EX-stage 3:1 operand-forward mux selects, the per-stage stall/flush
//   controls, and the data-memory wait freeze.
// PARAMETERS
// - REG_AW    5  register-address width (x0..x31; x0 never forwarded)
// - CNT_W    32  perf-counter width (only with HFC_PERF_CNT_EN)
// PORTS
// - clk          in   1      pipeline clock, rising edge
// - rst_n        in   1      asynchronous active-low reset
// - valid_d      in   1      ID-stage instruction valid
// - rs1_d        in   REG_AW ID source 1;  rs2_d same width = ID source 2
// - rd_d         in   REG_AW ID destination
// - regwrite_d   in   1      ID instr writes rd
// - load_d       in   1      ID instr is a load (result from dmem)
// - pc_src_e     in   1      EX branch/jump taken (redirect)
// - mem_wait_m   in   1      dmem not ready; freeze whole pipe
// - forward_a_e  out  2      EX mux A sel: 00 regfile, 01 WB result, 10 MEM ALU result
// - forward_b_e  out  2      same for operand B
// - stall_f      out  1      hold PC
// - stall_d      out  1      hold IF/ID
// - stall_e      out  1      hold ID/EX
// - stall_m      out  1      hold EX/MEM
// - flush_d      out  1      clear IF/ID
// - flush_e      out  1      clear ID/EX (bubble)
// BEHAVIOUR
// - Shadow regs: E{rs1,rs2,rd,regwrite,load}, M{rd,regwrite}, W{rd,regwrite}; all reset to 0.
// - Reset: all outputs 0 (forward 00, no stall/flush); FSM=RUN; async assert, sync release.
// - FSM RUN: shadow pipe advances each cycle; D->E captures ID fields gated by valid_d.
// - RUN -> MWAIT when mem_wait_m=1.
// - MWAIT: stall_f=stall_d=stall_e=stall_m=1, flush_*=0; shadow regs hold.
//   Forward selects keep being computed from the held E/M/W state.
// - MWAIT -> RUN on the first cycle mem_wait_m=0; stall/flush outputs are combinational
//   from state + inputs.
// - Forward A (B identical with rs2_e):
//   - 10 if regwrite_m && rd_m!=0 && rd_m==rs1_e;
//   - else 01 if regwrite_w && rd_w!=0 && rd_w==rs1_e;
//   - else 00. MEM beats WB on a double match.
//   - Zero-latency combinational decode of the registered shadow state.
// - Load-use, in RUN only: load_e && rd_e!=0 && valid_d && (rd_e==rs1_d || rd_e==rs2_d)
//   -> stall_f=stall_d=1, flush_e=1 for exactly one cycle.
//   - Bubble enters E (E.regwrite=E.load=0); the load then forwards from W via 01.
// - Branch, in RUN only: pc_src_e=1 -> flush_d=flush_e=1, no stall.
//   - Branch overrides load-use: D is squashed, so stall_f/stall_d=0 that cycle.
//   - Flushed slots enter E as bubbles.
// - Priority: mem_wait_m > pc_src_e > load-use > normal.
//   - A branch asserted during MWAIT is acted on in the first RUN cycle (EX held, so
//     pc_src_e stays valid).
// - rd_d=0 with regwrite_d=1 is tracked but never matches a forward/hazard (x0 rule).
// - Reset mid-stall: all state cleared immediately, stalls drop asynchronously.
// CONFIGURATION
// - HFC_PERF_CNT_EN defined:
//   - adds outputs stall_cnt, flush_cnt, wait_cnt (CNT_W each, reset 0).
//   - Per clk: +1 on a load-use stall cycle, +1 on a branch-flush cycle, +1 on an MWAIT
//     cycle.
//   - Counters saturate at all-ones.
// - HFC_PERF_CNT_EN undefined: those ports and counters are absent; all other behaviour
//   is identical.
// TESTING
// - Reset: rst_n=0 mid-traffic -> all outputs 0 same cycle; after release, forward_a_e=00
//   with any rs1.
// - EX->EX: `add x5` then `sub x6,x5,x7` -> forward_a_e=10, forward_b_e=00 in sub's EX
//   cycle; no stall.
// - Double match: x5 written by instrs in M and W, E reads x5 on rs2 -> forward_b_e=10.
//   - rd=0 writer in M, E reads x0 -> forward 00.
// - Load-use: `lw x8` then `add x9,x8,x1` -> one cycle stall_f=stall_d=flush_e=1;
//   - next cycle the add in E has forward_a_e=01; no further stall.
// - Branch+load-use same cycle: pc_src_e=1 with load-use condition -> flush_d=flush_e=1,
//   stall_f=stall_d=0.
// - mem_wait_m=1 for 3 cycles with pc_src_e=1 -> 3 cycles all stall_*=1, flush=0;
//   - flush_d=flush_e=1 on the 4th cycle.
//   - With HFC_PERF_CNT_EN, wait_cnt=3 and flush_cnt=1 afterwards.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - EX operand forwarding, load-use/branch hazards and dmem-wait freeze.
// Optional perf counters (stall_cnt/flush_cnt/wait_cnt) built when HFC_PERF_CNT_EN is defined.
module hazard_forward_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_d,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              regwrite_d,
  input  logic              load_d,
  input  logic              pc_src_e,
  input  logic              mem_wait_m,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e
`ifdef HFC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  wait_cnt
`endif
);

  localparam logic [REG_AW-1:0] X0 = '0;

  typedef enum logic {RUN, MWAIT} state_t;

  // Reset asserts asynchronously but is released two clocks later, in step with clk.
  logic [1:0] rst_pipe;
  logic       active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign active = rst_pipe[1];

  logic [REG_AW-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic              regwrite_e, load_e, regwrite_m, regwrite_w;
  state_t            state_next;
  logic              load_use, branch, frozen;

  // Freeze, redirect and load-use are resolved in that priority order.
  always_comb begin
    state_next = (active && mem_wait_m) ? MWAIT : RUN;
    frozen     = (state_next == MWAIT);
    branch     = active && !frozen && pc_src_e;
    load_use   = active && !frozen && load_e && (rd_e != X0) && valid_d &&
                 ((rd_e == rs1_d) || (rd_e == rs2_d));
  end

  always_comb begin
    stall_f = frozen || (load_use && !branch);
    stall_d = frozen || (load_use && !branch);
    stall_e = frozen;
    stall_m = frozen;
    flush_d = branch;
    flush_e = branch || load_use;
  end

  always_comb begin
    forward_a_e = 2'b00;
    if (regwrite_m && (rd_m != X0) && (rd_m == rs1_e))      forward_a_e = 2'b10;
    else if (regwrite_w && (rd_w != X0) && (rd_w == rs1_e)) forward_a_e = 2'b01;

    forward_b_e = 2'b00;
    if (regwrite_m && (rd_m != X0) && (rd_m == rs2_e))      forward_b_e = 2'b10;
    else if (regwrite_w && (rd_w != X0) && (rd_w == rs2_e)) forward_b_e = 2'b01;
  end

  // Shadow pipeline; a flushed or invalid ID slot enters E as an all-zero bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_e      <= '0;
      rs2_e      <= '0;
      rd_e       <= '0;
      regwrite_e <= 1'b0;
      load_e     <= 1'b0;
      rd_m       <= '0;
      regwrite_m <= 1'b0;
      rd_w       <= '0;
      regwrite_w <= 1'b0;
    end else if (active && !frozen) begin
      rd_w       <= rd_m;
      regwrite_w <= regwrite_m;
      rd_m       <= rd_e;
      regwrite_m <= regwrite_e;
      if (valid_d && !flush_e) begin
        rs1_e      <= rs1_d;
        rs2_e      <= rs2_d;
        rd_e       <= rd_d;
        regwrite_e <= regwrite_d;
        load_e     <= load_d;
      end else begin
        rs1_e      <= '0;
        rs2_e      <= '0;
        rd_e       <= '0;
        regwrite_e <= 1'b0;
        load_e     <= 1'b0;
      end
    end
  end

`ifdef HFC_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (load_use && !branch && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_ONE;
      if (branch && flush_cnt != CNT_MAX)              flush_cnt <= flush_cnt + CNT_ONE;
      if (frozen && wait_cnt != CNT_MAX)               wait_cnt  <= wait_cnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - directed vector table plus randomized traffic against a stage-list model.
module tb_hazard_forward_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_d = 1'b0;
  logic [4:0] rs1_d = '0, rs2_d = '0, rd_d = '0;
  logic       regwrite_d = 1'b0, load_d = 1'b0, pc_src_e = 1'b0, mem_wait_m = 1'b0;
  logic [1:0] forward_a_e, forward_b_e;
  logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
`ifdef HFC_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, wait_cnt;
`endif

  hazard_forward_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .regwrite_d(regwrite_d), .load_d(load_d), .pc_src_e(pc_src_e), .mem_wait_m(mem_wait_m),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .stall_f(stall_f), .stall_d(stall_d),
    .stall_e(stall_e), .stall_m(stall_m), .flush_d(flush_d), .flush_e(flush_e)
`ifdef HFC_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v; int rs1; int rs2; int rd; bit rw; bit ld; bit pc; bit mw;
    int fa; int fb; bit sf; bit sd; bit se; bit sm; bit fd; bit fe;
  } vec_t;

  typedef struct {
    int rs1; int rs2; int rd; bit rw; bit ld;
  } ins_t;

  int   n_pass = 0, n_total = 0;
  ins_t stg[3];  // 0 = EX, 1 = MEM, 2 = WB
  int   m_stall = 0, m_flush = 0, m_wait = 0;
  vec_t vecs[27];

  function automatic vec_t mk(bit v, int rs1, int rs2, int rd, bit rw, bit ld, bit pc, bit mw,
                              int fa, int fb, bit sf, bit sd, bit se, bit sm, bit fd, bit fe);
    vec_t t;
    t = '{v, rs1, rs2, rd, rw, ld, pc, mw, fa, fb, sf, sd, se, sm, fd, fe};
    return t;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int fwd(int rs);
    if (rs == 0) return 0;
    if (stg[1].rw && stg[1].rd == rs) return 2;
    if (stg[2].rw && stg[2].rd == rs) return 1;
    return 0;
  endfunction

  function automatic bit lu_now();
    return stg[0].ld && stg[0].rd != 0 && valid_d &&
           (stg[0].rd == int'(rs1_d) || stg[0].rd == int'(rs2_d));
  endfunction

  function automatic vec_t model_expect();
    vec_t t;
    bit lu;
    lu = lu_now() && !mem_wait_m;
    t.fa = fwd(stg[0].rs1);
    t.fb = fwd(stg[0].rs2);
    t.sf = mem_wait_m || (lu && !pc_src_e);
    t.sd = t.sf;
    t.se = mem_wait_m;
    t.sm = mem_wait_m;
    t.fd = !mem_wait_m && pc_src_e;
    t.fe = !mem_wait_m && (pc_src_e || lu);
    return t;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) stg[i] = '{0, 0, 0, 0, 0};
    m_stall = 0; m_flush = 0; m_wait = 0;
  endtask

  task automatic model_advance();
    vec_t e;
    e = model_expect();
    if (mem_wait_m) begin
      m_wait++;
    end else begin
      if (e.fd) m_flush++;
      if (e.sf) m_stall++;
      stg[2] = stg[1];
      stg[1] = stg[0];
      if (valid_d && !e.fe) stg[0] = '{int'(rs1_d), int'(rs2_d), int'(rd_d), regwrite_d, load_d};
      else                  stg[0] = '{0, 0, 0, 0, 0};
    end
  endtask

  task automatic compare_all(input string tag, input vec_t e);
    check({tag, " forward_a_e"}, forward_a_e, e.fa);
    check({tag, " forward_b_e"}, forward_b_e, e.fb);
    check({tag, " stall_f"}, stall_f, e.sf);
    check({tag, " stall_d"}, stall_d, e.sd);
    check({tag, " stall_e"}, stall_e, e.se);
    check({tag, " stall_m"}, stall_m, e.sm);
    check({tag, " flush_d"}, flush_d, e.fd);
    check({tag, " flush_e"}, flush_e, e.fe);
  endtask

  // Inputs are already applied; sample mid-cycle, then step the model on the edge.
  task automatic run_cycle(input string tag, input bit use_vec, input vec_t tv);
    #4;
    if (use_vec) compare_all(tag, tv);
    else         compare_all(tag, model_expect());
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic apply(input vec_t t);
    valid_d = t.v; rs1_d = 5'(t.rs1); rs2_d = 5'(t.rs2); rd_d = 5'(t.rd);
    regwrite_d = t.rw; load_d = t.ld; pc_src_e = t.pc; mem_wait_m = t.mw;
  endtask

  initial begin
    vec_t z;
    //            v rs1 rs2 rd rw ld pc mw | fa fb sf sd se sm fd fe
    vecs[0]  = mk(1, 1, 2, 5,  1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 5, 7, 6,  1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0,  0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 0, 0, 5,  1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 0, 0, 5,  1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(1, 3, 5, 10, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 2, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 1, 2, 0,  1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 0, 0, 11, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[12] = mk(1, 2, 0, 8,  1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[13] = mk(1, 8, 1, 9,  1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0, 1);
    vecs[14] = mk(1, 8, 1, 9,  1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[17] = mk(1, 1, 0, 4,  1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[18] = mk(1, 4, 0, 12, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1, 1);
    vecs[19] = mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[20] = mk(1, 0, 0, 1,  1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[21] = mk(1, 1, 2, 13, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[22] = mk(0, 0, 0, 0,  0, 0, 1, 1,  2, 0, 1, 1, 1, 1, 0, 0);
    vecs[23] = mk(0, 0, 0, 0,  0, 0, 1, 1,  2, 0, 1, 1, 1, 1, 0, 0);
    vecs[24] = mk(0, 0, 0, 0,  0, 0, 1, 1,  2, 0, 1, 1, 1, 1, 0, 0);
    vecs[25] = mk(0, 0, 0, 0,  0, 0, 1, 0,  2, 0, 0, 0, 0, 0, 1, 1);
    vecs[26] = mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();

    // Held in reset with hazard-causing inputs: every output must stay low.
    mem_wait_m = 1'b1; pc_src_e = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    compare_all("in_reset", z);
    mem_wait_m = 1'b0; pc_src_e = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 27; i++) begin
      apply(vecs[i]);
      run_cycle($sformatf("vec%0d", i), 1'b1, vecs[i]);
    end
`ifdef HFC_PERF_CNT_EN
    check("stall_cnt", stall_cnt, 1);
    check("flush_cnt", flush_cnt, 2);
    check("wait_cnt", wait_cnt, 3);
`endif

    for (int i = 0; i < 400; i++) begin
      valid_d    = ($urandom_range(3) != 0);
      rs1_d      = 5'($urandom_range(7));
      rs2_d      = 5'($urandom_range(7));
      rd_d       = 5'($urandom_range(7));
      regwrite_d = ($urandom_range(3) != 0);
      load_d     = ($urandom_range(2) == 0);
      pc_src_e   = ($urandom_range(7) == 0);
      mem_wait_m = ($urandom_range(5) == 0);
      run_cycle($sformatf("rnd%0d", i), 1'b0, z);
    end
`ifdef HFC_PERF_CNT_EN
    check("rnd stall_cnt", stall_cnt, m_stall);
    check("rnd flush_cnt", flush_cnt, m_flush);
    check("rnd wait_cnt", wait_cnt, m_wait);
`endif

    // Reset asserted mid-freeze: stalls must drop without waiting for a clock.
    mem_wait_m = 1'b1; pc_src_e = 1'b1; valid_d = 1'b1;
    #2;
    check("pre_reset stall_f", stall_f, 1);
    rst_n = 1'b0;
    #1;
    compare_all("mid_reset", z);
`ifdef HFC_PERF_CNT_EN
    check("mid_reset wait_cnt", wait_cnt, 0);
`endif
    model_clear();
    @(posedge clk); #1;
    mem_wait_m = 1'b0; pc_src_e = 1'b0; valid_d = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      valid_d = 1'b1;
      rs1_d = 5'($urandom_range(31));
      rs2_d = 5'($urandom_range(31));
      rd_d = 5'($urandom_range(31));
      regwrite_d = 1'b1; load_d = 1'b0;
      #4;
      if (i == 0) check("post_reset forward_a_e", forward_a_e, 0);
      #0;
      run_cycle($sformatf("post%0d", i), 1'b0, z);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
